// File: rtl/dense_layer_engine_if.sv
// rtl/dense_layer_engine_if.sv - Control, input/output data and weight-write bundle for dense_layer_engine
interface dense_layer_engine_if #(
    parameter int N_IN   = 30,
    parameter int N_OUT  = 5,
    parameter int DATA_W = 10,
    parameter int W_W    = 10
) ();
    localparam int N_W = N_IN * N_OUT;
    localparam int AW  = (N_W > 1) ? $clog2(N_W) : 1;

    logic                      Start;
    logic                      Init;
    logic [15:0]               Seed;
    logic [N_IN*DATA_W-1:0]    In;
    logic                      Wr_en;
    logic [AW-1:0]             Wr_addr;
    logic [W_W-1:0]            Wr_data;
    logic [N_OUT*DATA_W-1:0]   Out;
    logic                      Busy;
    logic                      Done;
    logic [1:0]                State;

    modport master (
        output Start, Init, Seed, In, Wr_en, Wr_addr, Wr_data,
        input  Out, Busy, Done, State
    );

    modport slave (
        input  Start, Init, Seed, In, Wr_en, Wr_addr, Wr_data,
        output Out, Busy, Done, State
    );
endinterface

// File: rtl/dense_layer_engine.sv
// rtl/dense_layer_engine.sv - One-MAC-per-cycle dense layer with ReLU and saturation
// Optional LFSR weight initialisation enabled by macro DENSE_LAYER_LFSR_INIT_EN.
module dense_layer_engine #(
    parameter int N_IN   = 30,
    parameter int N_OUT  = 5,
    parameter int DATA_W = 10,
    parameter int W_W    = 10,
    parameter int SHIFT  = 8
) (
    input  logic                 Clock,
    input  logic                 Rst,
    dense_layer_engine_if.slave  bus
);
    localparam int N_W   = N_IN * N_OUT;
    localparam int AW    = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int ACC_W = DATA_W + W_W + 1 + $clog2(N_IN);
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_INIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state, state_d;
    logic                    done_q, done_d;

    logic [DATA_W-1:0]       in_arr  [N_IN];
    logic signed [W_W-1:0]   w_mem   [N_W];
    logic [DATA_W-1:0]       out_arr [N_OUT];
    logic [N_OUT*DATA_W-1:0] out_flat;

    logic signed [ACC_W-1:0] acc, prod, sum, shifted;
    logic [DATA_W-1:0]       in_sel, clipped;
    logic signed [W_W-1:0]   w_sel;
    logic [IW-1:0]           i_cnt;
    logic [JW-1:0]           j_cnt;
    logic [AW-1:0]           w_idx;

    logic start_mac, last_prod, last_neuron;

    assign start_mac   = bus.Start & ~bus.Init;
    assign last_prod   = (i_cnt == IW'(N_IN - 1));
    assign last_neuron = (j_cnt == JW'(N_OUT - 1));

`ifdef DENSE_LAYER_LFSR_INIT_EN
    logic        start_init, last_w;
    logic [15:0] lfsr, lfsr_next;

    assign start_init = bus.Start & bus.Init;
    assign last_w     = (w_idx == AW'(N_W - 1));
    assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`else
    logic unused_seed;
    assign unused_seed = ^bus.Seed;
`endif

    // w_idx walks j*N_IN+i alongside the i/j counters, so it addresses the weight directly
    assign in_sel  = in_arr[i_cnt];
    assign w_sel   = w_mem[w_idx];
    assign prod    = ACC_W'($signed({1'b0, in_sel})) * ACC_W'(w_sel);
    assign sum     = acc + prod;
    assign shifted = sum >>> SHIFT;

    always_comb begin
        clipped = shifted[DATA_W-1:0];
        if (shifted[ACC_W-1]) begin
            clipped = '0;
        end else if (shifted > OUT_MAX) begin
            clipped = '1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= done_d;
        end
    end

    // DONE lasts two cycles: the first lets the final Out write settle, the second carries the pulse
    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_mac) begin
                    state_d = S_MAC;
                end
`ifdef DENSE_LAYER_LFSR_INIT_EN
                else if (start_init) begin
                    state_d = S_INIT;
                end
`endif
            end
            S_MAC: begin
                if (last_prod && last_neuron) begin
                    state_d = S_DONE;
                end
            end
`ifdef DENSE_LAYER_LFSR_INIT_EN
            S_INIT: begin
                if (last_w) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            for (int n = 0; n < N_IN; n++)  in_arr[n]  <= '0;
            for (int n = 0; n < N_W; n++)   w_mem[n]   <= '0;
            for (int n = 0; n < N_OUT; n++) out_arr[n] <= '0;
            acc   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            w_idx <= '0;
`ifdef DENSE_LAYER_LFSR_INIT_EN
            lfsr  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // a write coinciding with Start lands before the first MAC read
                    if (bus.Wr_en && (32'(bus.Wr_addr) < N_W)) begin
                        w_mem[bus.Wr_addr] <= $signed(bus.Wr_data);
                    end
                    if (start_mac) begin
                        for (int n = 0; n < N_IN; n++) begin
                            in_arr[n] <= bus.In[n*DATA_W +: DATA_W];
                        end
                        acc   <= '0;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        w_idx <= '0;
                    end
`ifdef DENSE_LAYER_LFSR_INIT_EN
                    else if (start_init) begin
                        lfsr  <= (bus.Seed == 16'h0000) ? 16'hACE1 : bus.Seed;
                        w_idx <= '0;
                    end
`endif
                end
                S_MAC: begin
                    w_idx <= w_idx + AW'(1);
                    if (last_prod) begin
                        out_arr[j_cnt] <= clipped;
                        acc            <= '0;
                        i_cnt          <= '0;
                        j_cnt          <= j_cnt + JW'(1);
                    end else begin
                        acc   <= sum;
                        i_cnt <= i_cnt + IW'(1);
                    end
                end
`ifdef DENSE_LAYER_LFSR_INIT_EN
                S_INIT: begin
                    lfsr         <= lfsr_next;
                    w_mem[w_idx] <= $signed(lfsr_next[W_W-1:0]);
                    w_idx        <= w_idx + AW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        out_flat = '0;
        for (int n = 0; n < N_OUT; n++) begin
            out_flat[n*DATA_W +: DATA_W] = out_arr[n];
        end
    end

    assign bus.Out   = out_flat;
    assign bus.Busy  = (state == S_MAC) || (state == S_INIT);
    assign bus.Done  = done_q;
    assign bus.State = state;
endmodule

// File: doc/dense_layer_engine.md
DENSE_LAYER_ENGINE -- requirements
Module: dense_layer_engine

Interface
REQ-001 SHALL have parameters: N_IN, default 30, number of layer inputs.
REQ-002 SHALL have parameter N_OUT, default 5, number of neurons.
REQ-003 SHALL have parameter DATA_W, default 10, unsigned input/output width.
REQ-004 SHALL have parameter W_W, default 10, signed weight width, 2..16.
REQ-005 SHALL have parameter SHIFT, default 8, arithmetic right-shift applied to each neuron sum.
REQ-006 SHALL have ports: Clock  in  1  single clock, rising edge.
REQ-007 SHALL have ports: Rst  in  1  synchronous reset, active-high.
REQ-008 SHALL have ports: Start  in  1  begin operation, sampled in IDLE only.
REQ-009 SHALL have ports: Init  in  1  with Start, selects weight initialisation instead of forward pass.
REQ-010 SHALL have ports: Seed  in  16  LFSR seed for initialisation.
REQ-011 SHALL have ports: In  in  N_IN*DATA_W  packed unsigned inputs, In[i] at bits i*DATA_W.
REQ-012 SHALL have ports: Wr_en  in  1, Wr_addr  in  clog2(N_IN*N_OUT), Wr_data  in  W_W  weight write port, addr = j*N_IN+i.
REQ-013 SHALL have ports: Out  out  N_OUT*DATA_W  packed unsigned neuron outputs.
REQ-014 SHALL have ports: Busy  out  1; Done  out  1; State  out  2.

Function
REQ-015 SHALL implement states IDLE=0, MAC=1, INIT=2, DONE=3, visible on State.
REQ-016 SHALL, in IDLE on Start=1, Init=0: latch In at that edge, enter MAC.
REQ-017 SHALL in MAC perform one product In[i]*W[j][i] per cycle, i fastest, j=0..N_OUT-1, N_IN*N_OUT cycles total.
REQ-018 SHALL use signed accumulator of width DATA_W+W_W+1+clog2(N_IN), cleared at start of each neuron.
REQ-019 SHALL on neuron j's last product: compute (acc >>> SHIFT); negative -> 0 (ReLU); > 2^DATA_W-1 -> 2^DATA_W-1; write Out[j] at that edge.
REQ-020 SHALL enter DONE after last neuron; Done=1 for exactly one cycle in DONE; then IDLE.
REQ-021 SHALL give latency: Start sampled at edge k -> Done high in cycle after edge k+N_IN*N_OUT+1.
REQ-022 SHALL drive Busy=1 in MAC and INIT, 0 otherwise.
REQ-023 SHALL ignore Start and Wr_en outside IDLE; Out[j] not written by MAC holds previous value.
REQ-024 SHALL, when Wr_en and Start coincide in IDLE, commit the write first; the pass uses the new weight.
REQ-025 SHALL leave In changes after the Start edge without effect on the running pass.

Reset
REQ-026 SHALL on Rst=1 at a clock edge: State=IDLE, Out=0, Busy=0, Done=0, all weights=0, accumulator and counters=0.
REQ-027 SHALL abort any MAC or INIT on Rst mid-operation with no Done pulse.

Configuration
REQ-028 SHALL gate weight initialisation with macro DENSE_LAYER_LFSR_INIT_EN.
REQ-029 SHALL with DENSE_LAYER_LFSR_INIT_EN defined: Start=1, Init=1 in IDLE loads LFSR with Seed (Seed=0 replaced by 16'hACE1), enters INIT.
REQ-030 SHALL in INIT advance a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, shift left) once per cycle and write its low W_W bits to weight address 0,1,...,N_IN*N_OUT-1, then enter DONE.
REQ-031 SHALL without DENSE_LAYER_LFSR_INIT_EN: Start=1 with Init=1 is ignored, state stays IDLE, no INIT logic or LFSR present; Init and Seed unused.

Verification (N_IN=30, N_OUT=5, DATA_W=10, W_W=10, SHIFT=8)
REQ-032 SHALL cover: Rst high 2 cycles -> Out=0, Busy=0, Done=0, State=0.
REQ-033 SHALL cover: all weights 1, all In 256, Start -> every Out[j]=30; Done in cycle after edge k+151; Busy high 150 cycles.
REQ-034 SHALL cover: all weights -1 (10'h3FF), all In 500 -> every Out[j]=0.
REQ-035 SHALL cover: all weights 511, all In 1023 -> every Out[j]=1023 (saturation); Start pulsed during MAC -> no restart, single Done.
REQ-036 SHALL cover: Rst asserted at edge k+50 of a pass -> State=0, Out=0, no Done; next Start completes normally.
REQ-037 SHALL cover: macro defined, Seed=0, Start+Init -> Busy 150 cycles, Done, weights equal bench LFSR model from 16'hACE1; macro undefined -> State stays 0, Done never asserts.
